// File: rtl/fifo_pkg.sv
// Shared defaults and FIFO word layout for the FIFO write arbiter slice.
// A FIFO word is {id, payload}: the payload sits in the low bits and the ID directly above it.
package fifo_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned IDW_DEF   = 2;

  // The payload occupies [WIDTH-1:0], so the ID field starts at bit WIDTH.
  function automatic int unsigned fifo_id_lsb(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned fifo_word_w(input int unsigned idw, input int unsigned width);
    return idw + width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;

  // Two passes: first the upper part [ptr..NREQ-1], then the wrapped part [0..ptr-1].
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i < 32'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Multi-requester write arbiter in front of a FIFO, with a 2-entry read-side output buffer.
// Words carry the originating requester ID so the consumer can attribute each payload.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_write_en,
  output logic [IDW+WIDTH-1:0]  fifo_data_in,
  input  logic                  fifo_full,
  output logic                  fifo_read_en,
  input  logic [IDW+WIDTH-1:0]  fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_error,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  err_sticky
);

  localparam int unsigned FW     = fifo_word_w(IDW, WIDTH);
  localparam int unsigned ID_LSB = fifo_id_lsb(WIDTH);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [FW-1:0]    buf0_q, buf0_d;
  logic [FW-1:0]    buf1_q, buf1_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             wr_any;
  logic [WIDTH-1:0] wr_payload;
  logic             pop;
  logic [2:0]       occ;

  assign arb_req = (rst || fifo_full) ? '0 : req_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Write side: grant is one-hot, so an OR-mux picks the winner payload.
  always_comb begin
    wr_payload = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) wr_payload = wr_payload | req_data[i*WIDTH +: WIDTH];
    end
    wr_any        = |gnt;
    req_ready     = gnt;
    fifo_write_en = wr_any;
    fifo_data_in  = '0;
    if (wr_any) begin
      fifo_data_in[ID_LSB +: IDW] = gnt_idx;
      fifo_data_in[WIDTH-1:0]     = wr_payload;
    end
    ptr_d = ptr_q;
    if (wr_any) ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
  end

  // Read side: issue a read only if the returning word is sure to find a free slot.
  always_comb begin
    pop          = ~rst & (cnt_q != 2'd0) & out_ready;
    occ          = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
    fifo_read_en = ~rst & ~fifo_empty & (occ < 3'd2);
    pend_d       = fifo_read_en;
    cnt_d        = cnt_q + 2'(pend_q) - 2'(pop);
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    case ({pop, pend_q})
      2'b01: begin
        if (cnt_q == 2'd0) buf0_d = fifo_data_out;
        else               buf1_d = fifo_data_out;
      end
      2'b10: buf0_d = buf1_q;
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = fifo_data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data_out;
        end
      end
      default: ;
    endcase
    err_d = err_q | fifo_error;
  end

  always_comb begin
    out_valid = ~rst & (cnt_q != 2'd0);
    out_data  = '0;
    out_id    = '0;
    if (out_valid) begin
      out_data = buf0_q[WIDTH-1:0];
      out_id   = buf0_q[ID_LSB +: IDW];
    end
    err_sticky = err_q;
  end

  // Clearing pend_q on reset drops any read data still returning from before the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      buf0_q <= '0;
      buf1_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of write requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, meaning payload width per requester.
REQ-003 SHALL have parameter IDW, default 2, meaning requester-ID width, equal to clog2(NREQ).
REQ-004 SHALL have port clk  input  1  clock; rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-007 SHALL have port req_data  input  NREQ*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  NREQ  one-hot accept, combinational.
REQ-009 SHALL have port fifo_write_en  output  1  FIFO write strobe.
REQ-010 SHALL have port fifo_data_in  output  IDW+WIDTH  FIFO word {id, payload}.
REQ-011 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-012 SHALL have port fifo_read_en  output  1  FIFO read strobe.
REQ-013 SHALL have port fifo_data_out  input  IDW+WIDTH  FIFO read data, valid the cycle after fifo_read_en.
REQ-014 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-015 SHALL have port fifo_error  input  1  FIFO over/underflow indication.
REQ-016 SHALL have port out_valid  output  1  consumer data valid.
REQ-017 SHALL have port out_ready  input  1  consumer accept.
REQ-018 SHALL have port out_data  output  WIDTH  consumer payload.
REQ-019 SHALL have port out_id  output  IDW  originating requester of out_data.
REQ-020 SHALL have port err_sticky  output  1  latched fifo_error.

Function
REQ-021 Write arbitration SHALL be round-robin: the first valid requester at or after rr_ptr (modulo NREQ) wins.
REQ-022 A grant SHALL be issued only when fifo_full=0; fifo_write_en=|req_ready; a write = req_valid[i]&req_ready[i] in one cycle.
REQ-023 fifo_data_in SHALL be {winner index, winner payload}, zero when no grant.
REQ-024 After each write, rr_ptr SHALL become (winner+1) mod NREQ on the next edge; with no write, rr_ptr holds.
REQ-025 When fifo_full=1, all req_ready SHALL be 0; requesters hold valid/data (no drop, no write to a full FIFO).
REQ-026 Read side SHALL use a 2-entry output buffer; pending = reads issued whose data is still due next cycle (0 or 1).
REQ-027 fifo_read_en SHALL assert iff fifo_empty=0 and (buffer occupancy + pending - pop this cycle) < 2.
REQ-028 Data returned one cycle after fifo_read_en SHALL be captured into the buffer tail in order.
REQ-029 out_valid/out_data/out_id SHALL present the buffer head; pop when out_valid&out_ready.
REQ-030 Sustained throughput SHALL be one word per cycle when producers and consumer are not stalled; latency from FIFO nonempty to out_valid SHALL be 2 cycles.
REQ-031 Simultaneous write and read in one cycle SHALL be permitted and independent.
REQ-032 Ordering SHALL be preserved: out stream equals FIFO write order.
REQ-033 err_sticky SHALL set on any cycle with fifo_error=1 and hold until reset.

Reset
REQ-034 On rst=1 at a clock edge: rr_ptr=0, buffer empty, pending=0, err_sticky=0.
REQ-035 During rst, req_ready=0, fifo_write_en=0, fifo_read_en=0, out_valid=0, out_data=0, out_id=0.
REQ-036 Reset mid-transfer SHALL discard in-flight read data arriving the cycle after reset; the FIFO is reset on the same rst.

Structure
REQ-037 Shared package fifo_pkg SHALL hold NREQ/WIDTH/IDW defaults and the FIFO word-layout constants (ID field position).
REQ-038 The round-robin selector SHALL be a sub-module rr_arbiter (NREQ-bit request in, one-hot grant out, pointer in).
REQ-039 Block SHALL be verified attached to the team 16-deep FIFO with its WIDTH = IDW+WIDTH.

Verification
REQ-040 All 4 requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,1,... one per cycle; out_id repeats 0,1,2,3.
REQ-041 Only requester 2 valid, 20 words 0x00..0x13, out_ready=0 -> 16 accepted plus 2 in the output buffer (18 total), req_ready=0 thereafter, err_sticky stays 0.
REQ-042 Then out_ready=1 -> outputs 0x00..0x13 in order with out_id=2; no gaps after the first.
REQ-043 FIFO empty, out_ready=1 -> fifo_read_en never asserts, out_valid=0, err_sticky=0.
REQ-044 Requesters 1 and 3 valid, rr_ptr=2 -> grant 3 first, then 1.
REQ-045 rst asserted with 5 words queued and a read pending -> next cycle out_valid=0, rr_ptr=0, no stale word appears afterward.
